// File: rtl/char_buf_arb_if.sv
// rtl/char_buf_arb_if.sv - requester, RAM and status signals of the character buffer arbiter
interface char_buf_arb_if;
    logic        R_REQ;
    logic [15:0] R_ADDR;
    logic        R_GNT;
    logic        R_VALID;
    logic [15:0] R_DATA;

    logic        C_REQ;
    logic        C_WE;
    logic [15:0] C_ADDR;
    logic [15:0] C_WDATA;
    logic        C_GNT;
    logic        C_VALID;
    logic [15:0] C_RDATA;

    logic [15:0] MEM_ADDR;
    logic        MEM_WE;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;

    logic        ERR;

    modport master (
        output R_REQ, R_ADDR, C_REQ, C_WE, C_ADDR, C_WDATA, MEM_RDATA,
        input  R_GNT, R_VALID, R_DATA, C_GNT, C_VALID, C_RDATA,
               MEM_ADDR, MEM_WE, MEM_WDATA, ERR
    );

    modport slave (
        input  R_REQ, R_ADDR, C_REQ, C_WE, C_ADDR, C_WDATA, MEM_RDATA,
        output R_GNT, R_VALID, R_DATA, C_GNT, C_VALID, C_RDATA,
               MEM_ADDR, MEM_WE, MEM_WDATA, ERR
    );
endinterface

// File: rtl/char_buf_arb.sv
// rtl/char_buf_arb.sv - renderer/CPU arbiter for the character buffer in shared RAM
module char_buf_arb #(
    parameter logic [15:0] CHA_BUF_BASE  = 16'h0000,
    parameter int          CHA_BUF_WORDS = 1200,
    parameter int          STARVE_MAX    = 4
) (
    input  logic          CLK50MHz,
    input  logic          RESETn,
    char_buf_arb_if.slave bus
);
    localparam logic [16:0] WORDS_LIM = 17'(CHA_BUF_WORDS);
    localparam logic [3:0]  SMAX      = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt;
    logic        cpu_first;
    logic        r_xfer;
    logic        c_xfer;
    logic        xfer;
    logic        rd_issue;
    logic [15:0] off;
    logic        oor;

    logic        t1_valid, t1_owner, t1_oor;
    logic        t2_valid, t2_owner, t2_oor;

    // The CPU only overrides the renderer once it has lost STARVE_MAX times in a row.
    assign cpu_first   = (starve_cnt == SMAX);
    assign bus.R_GNT   = RESETn && bus.R_REQ && !(bus.C_REQ && cpu_first);
    assign bus.C_GNT   = RESETn && bus.C_REQ && (!bus.R_REQ || cpu_first);

    assign r_xfer   = bus.R_REQ && bus.R_GNT;
    assign c_xfer   = bus.C_REQ && bus.C_GNT;
    assign xfer     = r_xfer || c_xfer;
    assign rd_issue = r_xfer || (c_xfer && !bus.C_WE);
    assign off      = r_xfer ? bus.R_ADDR : bus.C_ADDR;
    assign oor      = ({1'b0, off} >= WORDS_LIM);

    always_ff @(posedge CLK50MHz or negedge RESETn) begin
        if (!RESETn) begin
            starve_cnt <= 4'd0;
        end else if (!bus.C_REQ || c_xfer) begin
            starve_cnt <= 4'd0;
        end else if (r_xfer && starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK50MHz or negedge RESETn) begin
        if (!RESETn) begin
            bus.MEM_ADDR  <= 16'h0000;
            bus.MEM_WE    <= 1'b0;
            bus.MEM_WDATA <= 16'h0000;
            bus.ERR       <= 1'b0;
        end else begin
            bus.MEM_WE <= c_xfer && bus.C_WE && !oor;
            if (xfer) begin
                bus.MEM_ADDR  <= CHA_BUF_BASE + off;
                bus.MEM_WDATA <= bus.C_WDATA;
                if (oor) begin
                    bus.ERR <= 1'b1;
                end
            end
        end
    end

    // Tag stage 2 lines up with the cycle in which MEM_RDATA answers the sampled address.
    always_ff @(posedge CLK50MHz or negedge RESETn) begin
        if (!RESETn) begin
            t1_valid    <= 1'b0;
            t1_owner    <= 1'b0;
            t1_oor      <= 1'b0;
            t2_valid    <= 1'b0;
            t2_owner    <= 1'b0;
            t2_oor      <= 1'b0;
            bus.R_VALID <= 1'b0;
            bus.C_VALID <= 1'b0;
            bus.R_DATA  <= 16'h0000;
            bus.C_RDATA <= 16'h0000;
        end else begin
            t1_valid    <= rd_issue;
            t1_owner    <= c_xfer;
            t1_oor      <= oor;
            t2_valid    <= t1_valid;
            t2_owner    <= t1_owner;
            t2_oor      <= t1_oor;
            bus.R_VALID <= t2_valid && !t2_owner;
            bus.C_VALID <= t2_valid && t2_owner;
            if (t2_valid) begin
                if (t2_owner) begin
                    bus.C_RDATA <= t2_oor ? 16'h0000 : bus.MEM_RDATA;
                end else begin
                    bus.R_DATA  <= t2_oor ? 16'h0000 : bus.MEM_RDATA;
                end
            end
        end
    end
endmodule

// File: tb/tb_char_buf_arb.sv
// tb/tb_char_buf_arb.sv - self-checking bench for char_buf_arb
module tb_char_buf_arb;
    localparam logic [15:0] BASE   = 16'h0000;
    localparam int          WORDS  = 1200;
    localparam int          SMAX   = 4;

    logic CLK50MHz;
    logic RESETn;
    char_buf_arb_if bus ();

    char_buf_arb #(.CHA_BUF_BASE(BASE), .CHA_BUF_WORDS(WORDS), .STARVE_MAX(SMAX)) dut (
        .CLK50MHz (CLK50MHz),
        .RESETn   (RESETn),
        .bus      (bus)
    );

    initial CLK50MHz = 1'b0;
    always #10 CLK50MHz = ~CLK50MHz;

    // RAM stub: unwritten words read back as their own address.
    logic [15:0] ram [0:65535];
    bit          ram_f [0:65535];
    always @(posedge CLK50MHz) begin
        if (bus.MEM_WE === 1'b1) begin
            ram[bus.MEM_ADDR]   <= bus.MEM_WDATA;
            ram_f[bus.MEM_ADDR] <= 1'b1;
        end
        bus.MEM_RDATA <= ram_f[bus.MEM_ADDR] ? ram[bus.MEM_ADDR] : bus.MEM_ADDR;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: predicted outputs after each edge, reads queued with their due edge.
    typedef struct {
        int          due;
        bit          own;
        logic [15:0] d;
    } rd_t;
    rd_t         pq[$];
    logic [15:0] mm [0:65535];
    bit          mm_f [0:65535];
    int          m_cyc = 0;
    int          m_starve = 0;
    logic [15:0] m_addr = 0, m_wd = 0, m_rd = 0, m_cd = 0;
    logic        m_we = 0, m_rv = 0, m_cv = 0, m_err = 0;

    always @(negedge CLK50MHz) begin
        logic        e_rg, e_cg, oor;
        logic [15:0] off, a;
        if (!RESETn) begin
            m_starve = 0; m_addr = 0; m_wd = 0; m_rd = 0; m_cd = 0;
            m_we = 0; m_rv = 0; m_cv = 0; m_err = 0;
            pq.delete();
        end
        e_rg = RESETn && bus.R_REQ && !(bus.C_REQ && m_starve == SMAX);
        e_cg = RESETn && bus.C_REQ && !e_rg;
        chk("r_gnt",     32'(bus.R_GNT),     32'(e_rg));
        chk("c_gnt",     32'(bus.C_GNT),     32'(e_cg));
        chk("mem_addr",  32'(bus.MEM_ADDR),  32'(m_addr));
        chk("mem_we",    32'(bus.MEM_WE),    32'(m_we));
        chk("mem_wdata", 32'(bus.MEM_WDATA), 32'(m_wd));
        chk("r_valid",   32'(bus.R_VALID),   32'(m_rv));
        chk("r_data",    32'(bus.R_DATA),    32'(m_rd));
        chk("c_valid",   32'(bus.C_VALID),   32'(m_cv));
        chk("c_rdata",   32'(bus.C_RDATA),   32'(m_cd));
        chk("err",       32'(bus.ERR),       32'(m_err));
        if (RESETn) begin
            m_cyc++;
            m_we = 0; m_rv = 0; m_cv = 0;
            if (pq.size() > 0 && pq[0].due == m_cyc) begin
                if (pq[0].own) begin m_cv = 1; m_cd = pq[0].d; end
                else           begin m_rv = 1; m_rd = pq[0].d; end
                void'(pq.pop_front());
            end
            if (e_rg || e_cg) begin
                off    = e_rg ? bus.R_ADDR : bus.C_ADDR;
                oor    = (int'(off) >= WORDS);
                a      = BASE + off;
                m_addr = a;
                m_wd   = bus.C_WDATA;
                if (oor) m_err = 1;
                if (e_cg && bus.C_WE) begin
                    if (!oor) begin m_we = 1; mm[a] = bus.C_WDATA; mm_f[a] = 1; end
                end else begin
                    pq.push_back('{m_cyc + 2, e_cg, oor ? 16'h0000 : (mm_f[a] ? mm[a] : a)});
                end
            end
            if (!bus.C_REQ || e_cg) m_starve = 0;
            else if (e_rg && m_starve < SMAX) m_starve++;
        end
    end

    task automatic tick();
        @(posedge CLK50MHz);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK50MHz);
    endtask

    logic [9:0] seq;
    logic [4:0] seq2;
    int         rv_seen;

    initial begin
        RESETn = 1'b0;
        bus.R_REQ = 1'b1; bus.R_ADDR = 16'd0;
        bus.C_REQ = 1'b0; bus.C_WE = 1'b0; bus.C_ADDR = 16'd0; bus.C_WDATA = 16'd0;
        at_neg();
        chk("rst_r_gnt",  32'(bus.R_GNT),  32'd0);
        chk("rst_mem_we", 32'(bus.MEM_WE), 32'd0);
        chk("rst_err",    32'(bus.ERR),    32'd0);
        tick(); tick();
        RESETn = 1'b1; bus.R_REQ = 1'b0;
        tick();

        // Renderer burst 3,4,5
        bus.R_REQ = 1'b1; bus.R_ADDR = 16'd3;
        at_neg();
        chk("burst_gnt", 32'(bus.R_GNT), 32'd1);
        tick();
        bus.R_ADDR = 16'd4;
        tick();
        bus.R_ADDR = 16'd5;
        at_neg();
        chk("burst_early_valid", 32'(bus.R_VALID), 32'd0);
        tick();
        bus.R_REQ = 1'b0;
        at_neg();
        chk("burst_v0", 32'(bus.R_VALID), 32'd1);
        chk("burst_d0", 32'(bus.R_DATA),  32'd3);
        tick(); at_neg();
        chk("burst_d1", 32'(bus.R_DATA),  32'd4);
        tick(); at_neg();
        chk("burst_d2", 32'(bus.R_DATA),  32'd5);
        tick(); at_neg();
        chk("burst_end_valid", 32'(bus.R_VALID), 32'd0);
        chk("burst_hold",      32'(bus.R_DATA),  32'd5);
        tick();

        // CPU write to offset 5
        bus.C_REQ = 1'b1; bus.C_WE = 1'b1; bus.C_ADDR = 16'd5; bus.C_WDATA = 16'h4142;
        at_neg();
        chk("wr_c_gnt", 32'(bus.C_GNT), 32'd1);
        chk("wr_r_gnt", 32'(bus.R_GNT), 32'd0);
        tick();
        bus.C_REQ = 1'b0;
        at_neg();
        chk("wr_mem_we",    32'(bus.MEM_WE),    32'd1);
        chk("wr_mem_addr",  32'(bus.MEM_ADDR),  32'd5);
        chk("wr_mem_wdata", 32'(bus.MEM_WDATA), 32'h4142);
        tick(); at_neg();
        chk("wr_we_drop", 32'(bus.MEM_WE), 32'd0);
        tick(); at_neg();
        chk("wr_no_cvalid", 32'(bus.C_VALID), 32'd0);
        tick();

        // Last in-range word, then read it back through the renderer
        bus.C_REQ = 1'b1; bus.C_WE = 1'b1; bus.C_ADDR = 16'd1199; bus.C_WDATA = 16'h1234;
        tick();
        bus.C_REQ = 1'b0;
        at_neg();
        chk("edge_mem_we", 32'(bus.MEM_WE), 32'd1);
        chk("edge_err",    32'(bus.ERR),    32'd0);
        tick();
        bus.R_REQ = 1'b1; bus.R_ADDR = 16'd1199;
        tick();
        bus.R_REQ = 1'b0;
        tick(); tick(); at_neg();
        chk("edge_rd_valid", 32'(bus.R_VALID), 32'd1);
        chk("edge_rd_data",  32'(bus.R_DATA),  32'h1234);
        tick();

        // Both requesting continuously
        bus.R_REQ = 1'b1; bus.R_ADDR = 16'd10;
        bus.C_REQ = 1'b1; bus.C_WE = 1'b0; bus.C_ADDR = 16'd20;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            seq[i] = bus.C_GNT;
            tick();
        end
        bus.R_REQ = 1'b0; bus.C_REQ = 1'b0;
        chk("starve_seq", 32'(seq), 32'(10'b1000010000));
        tick(); tick(); tick();

        // Out-of-range write then read
        bus.C_REQ = 1'b1; bus.C_WE = 1'b1; bus.C_ADDR = 16'd1200; bus.C_WDATA = 16'hBEEF;
        tick();
        bus.C_REQ = 1'b0;
        at_neg();
        chk("oor_mem_we", 32'(bus.MEM_WE), 32'd0);
        chk("oor_err",    32'(bus.ERR),    32'd1);
        tick(); tick(); at_neg();
        chk("oor_err_sticky", 32'(bus.ERR), 32'd1);
        tick();
        bus.C_REQ = 1'b1; bus.C_WE = 1'b0; bus.C_ADDR = 16'd1200;
        tick();
        bus.C_REQ = 1'b0;
        tick(); at_neg();
        chk("oor_rd_early", 32'(bus.C_VALID), 32'd0);
        tick(); at_neg();
        chk("oor_rd_valid", 32'(bus.C_VALID), 32'd1);
        chk("oor_rd_data",  32'(bus.C_RDATA), 32'd0);
        tick(); tick();

        // Reset with renderer reads in flight and the starvation counter at 3
        bus.R_REQ = 1'b1; bus.R_ADDR = 16'd7;
        bus.C_REQ = 1'b1; bus.C_WE = 1'b0; bus.C_ADDR = 16'd8;
        tick(); tick(); tick();
        RESETn = 1'b0; bus.R_REQ = 1'b0; bus.C_REQ = 1'b0;
        at_neg();
        chk("rst_mem_addr",  32'(bus.MEM_ADDR),  32'd0);
        chk("rst_mem_wdata", 32'(bus.MEM_WDATA), 32'd0);
        chk("rst_r_data",    32'(bus.R_DATA),    32'd0);
        chk("rst_c_rdata",   32'(bus.C_RDATA),   32'd0);
        chk("rst_err_clr",   32'(bus.ERR),       32'd0);
        tick();
        RESETn = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            if (bus.R_VALID !== 1'b0) rv_seen++;
            tick();
        end
        chk("rst_no_stale_valid", 32'(rv_seen), 32'd0);
        bus.R_REQ = 1'b1; bus.C_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            seq2[i] = bus.C_GNT;
            tick();
        end
        bus.R_REQ = 1'b0; bus.C_REQ = 1'b0;
        chk("rst_starve_restart", 32'(seq2), 32'(5'b10000));
        tick(); tick(); tick(); tick();
        at_neg();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
